// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART receiver.
//   DATA_BITS_DEF / OSR_DEF : default frame width and ticks per bit
//   ST_*                    : 3-bit receiver state encodings
package uart_pkg;

    localparam int DATA_BITS_DEF = 8;
    localparam int OSR_DEF       = 8;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_START    = 3'd1;
    localparam logic [2:0] ST_DATA     = 3'd2;
    localparam logic [2:0] ST_PARITY   = 3'd3;
    localparam logic [2:0] ST_STOP     = 3'd4;
    localparam logic [2:0] ST_BRK_WAIT = 3'd5;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous single-bit input.
//   clk, rst : clock and async active-high reset
//   d        : asynchronous input
//   q        : synchronized level (EDGE_EN=0) or one-cycle rising-edge pulse (EDGE_EN=1)
// RST_VAL presets every flop so the output is quiet right after reset.
module sync_edge #(
    parameter logic RST_VAL = 1'b0,
    parameter bit   EDGE_EN = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    if (EDGE_EN) begin : g_edge
        logic prev_q;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) prev_q <= RST_VAL;
            else     prev_q <= sync_q;
        end
        assign q = sync_q & ~prev_q;
    end else begin : g_level
        assign q = sync_q;
    end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver (start, DATA_BITS data LSB first, optional parity, stop).
//   fclk, rst   : system clock, async active-high reset
//   bclkx8      : oversampling tick from the baud generator (sampled as data)
//   rxd         : serial line, idle high
//   rd_ack      : host has consumed rx_data
//   rx_data     : received byte; rx_valid marks it unread
//   frame_err, parity_err : status of the byte in rx_data
//   overrun_err : a frame was dropped because rx_data was still unread
//   busy        : receiver is not idle
//
// state     | meaning
// IDLE      | waiting for a falling edge on the line
// START     | counting to mid start bit to reject glitches
// DATA      | sampling data bits at the end of each bit window
// PARITY    | sampling the parity bit
// STOP      | sampling the stop bit, frame completes here
// BRK_WAIT  | line held low after the stop bit, wait for it to go high
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DATA_BITS_DEF,
    parameter int OSR        = OSR_DEF,
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                 fclk,
    input  logic                 rst,
    input  logic                 bclkx8,
    input  logic                 rxd,
    input  logic                 rd_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int               SW       = $clog2(OSR);
    localparam logic [SW-1:0]    SAMP_MID = SW'(OSR / 2 - 1);
    localparam logic [SW-1:0]    SAMP_END = SW'(OSR - 1);
    localparam logic [2:0]       BIT_LAST = 3'(DATA_BITS - 1);

    logic rxd_s;
    logic tick;

    sync_edge #(.RST_VAL(1'b1), .EDGE_EN(1'b0)) u_sync_rxd (
        .clk (fclk),
        .rst (rst),
        .d   (rxd),
        .q   (rxd_s)
    );

    sync_edge #(.RST_VAL(1'b0), .EDGE_EN(1'b1)) u_sync_tick (
        .clk (fclk),
        .rst (rst),
        .d   (bclkx8),
        .q   (tick)
    );

    logic [2:0]           state_q, state_d;
    logic [SW-1:0]        samp_cnt_q, samp_cnt_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parity_ok_q, parity_ok_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 parity_err_q, parity_err_d;
    logic                 overrun_err_q, overrun_err_d;
    logic                 complete;
    logic                 samp_end;

    always_comb begin
        state_d     = state_q;
        samp_cnt_d  = samp_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        parity_ok_d = parity_ok_q;
        complete    = 1'b0;
        samp_end    = (samp_cnt_q == SAMP_END);

        if (tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (!rxd_s) begin
                        state_d    = ST_START;
                        samp_cnt_d = '0;
                    end
                end
                ST_START: begin
                    if (samp_cnt_q == SAMP_MID) begin
                        if (!rxd_s) begin
                            state_d    = ST_DATA;
                            samp_cnt_d = '0;
                            bit_cnt_d  = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        samp_cnt_d = samp_cnt_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (samp_end) begin
                        // New bits enter at the MSB so the first bit ends up at bit 0.
                        shift_d    = {rxd_s, shift_q[DATA_BITS-1:1]};
                        samp_cnt_d = '0;
                        if (bit_cnt_q == BIT_LAST) state_d = PARITY_EN ? ST_PARITY : ST_STOP;
                        else                       bit_cnt_d = bit_cnt_q + 1'b1;
                    end else begin
                        samp_cnt_d = samp_cnt_q + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (samp_end) begin
                        parity_ok_d = ~(^shift_q ^ rxd_s ^ PARITY_ODD);
                        samp_cnt_d  = '0;
                        state_d     = ST_STOP;
                    end else begin
                        samp_cnt_d = samp_cnt_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (samp_end) begin
                        complete   = 1'b1;
                        samp_cnt_d = '0;
                        state_d    = rxd_s ? ST_IDLE : ST_BRK_WAIT;
                    end else begin
                        samp_cnt_d = samp_cnt_q + 1'b1;
                    end
                end
                ST_BRK_WAIT: begin
                    if (rxd_s) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q;
        frame_err_d   = frame_err_q;
        parity_err_d  = parity_err_q;
        overrun_err_d = overrun_err_q;

        if (complete) begin
            // An acknowledge in the completion cycle frees the holding register.
            if (!rx_valid_q || rd_ack) begin
                rx_data_d     = shift_q;
                rx_valid_d    = 1'b1;
                frame_err_d   = ~rxd_s;
                parity_err_d  = PARITY_EN && !parity_ok_q;
                overrun_err_d = 1'b0;
            end else begin
                overrun_err_d = 1'b1;
            end
        end else if (rd_ack && rx_valid_q) begin
            rx_valid_d    = 1'b0;
            frame_err_d   = 1'b0;
            parity_err_d  = 1'b0;
            overrun_err_d = 1'b0;
        end
    end

    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            samp_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            parity_ok_q   <= 1'b1;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            parity_err_q  <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            samp_cnt_q    <= samp_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            parity_ok_q   <= parity_ok_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            frame_err_q   <= frame_err_d;
            parity_err_q  <= parity_err_d;
            overrun_err_q <= overrun_err_d;
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign frame_err   = frame_err_q;
    assign parity_err  = parity_err_q;
    assign overrun_err = overrun_err_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
module tb_uart_rx_os;

    logic       fclk = 1'b0;
    logic       rst = 1'b1;
    logic       bclkx8 = 1'b0;
    logic       rxd = 1'b1, rd_ack = 1'b0;
    logic       rxd_p = 1'b1, rd_ack_p = 1'b0;
    logic [7:0] rx_data, rx_data_p;
    logic       rx_valid, frame_err, parity_err, overrun_err, busy;
    logic       rx_valid_p, frame_err_p, parity_err_p, overrun_err_p, busy_p;

    int n_checks = 0;
    int n_fail   = 0;

    uart_rx_os u_dut (
        .fclk(fclk), .rst(rst), .bclkx8(bclkx8), .rxd(rxd), .rd_ack(rd_ack),
        .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
        .parity_err(parity_err), .overrun_err(overrun_err), .busy(busy)
    );

    uart_rx_os #(.PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_par (
        .fclk(fclk), .rst(rst), .bclkx8(bclkx8), .rxd(rxd_p), .rd_ack(rd_ack_p),
        .rx_data(rx_data_p), .rx_valid(rx_valid_p), .frame_err(frame_err_p),
        .parity_err(parity_err_p), .overrun_err(overrun_err_p), .busy(busy_p)
    );

    always #5 fclk = ~fclk;
    // Edges offset from every fclk edge; 8 fclk cycles per bclkx8 period.
    initial begin
        #2;
        forever #40 bclkx8 = ~bclkx8;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit         ack_first;
        logic [7:0] b;
        bit         stop;
        logic [7:0] e_data;
        bit         e_valid;
        bit         e_fe;
        bit         e_ov;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_line(input bit sel, input logic v);
        if (sel) rxd_p = v;
        else     rxd   = v;
    endtask

    task automatic bit_time();
        repeat (64) @(negedge fclk);
    endtask

    task automatic align();
        @(posedge bclkx8);
        @(negedge fclk);
    endtask

    // Start bit, data LSB first, optional parity bit (no stop bit).
    task automatic send_bits(input bit sel, input logic [7:0] b, input bit use_par, input logic pbit);
        align();
        set_line(sel, 1'b0);
        bit_time();
        for (int i = 0; i < 8; i++) begin
            set_line(sel, b[i]);
            bit_time();
        end
        if (use_par) begin
            set_line(sel, pbit);
            bit_time();
        end
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] b, input bit stop,
                              input bit use_par, input logic pbit);
        send_bits(sel, b, use_par, pbit);
        set_line(sel, stop);
        bit_time();
        set_line(sel, 1'b1);
        bit_time();
    endtask

    task automatic pulse_ack(input bit sel);
        @(negedge fclk);
        if (sel) rd_ack_p = 1'b1; else rd_ack = 1'b1;
        @(negedge fclk);
        if (sel) rd_ack_p = 1'b0; else rd_ack = 1'b0;
    endtask

    int         lat;
    logic [7:0] rb;
    bit         rstop, rack;
    logic       rpbit;
    logic [7:0] m_data;
    bit         m_valid, m_fe, m_ov;

    initial begin
        vecs[0] = '{1'b0, 8'hA5, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 8'h3C, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 8'h11, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 8'h22, 1'b1, 8'h11, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 8'h5A, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 8'hFF, 1'b0, 8'h5A, 1'b1, 1'b0, 1'b1};

        // Reset state
        repeat (3) @(negedge fclk);
        chk("rst_data", 32'(rx_data), 32'h0);
        chk("rst_flags", 32'({rx_valid, frame_err, parity_err, overrun_err, busy}), 32'h0);
        chk("rst_par_valid", 32'({rx_valid_p, busy_p}), 32'h0);
        rst = 1'b0;
        repeat (20) @(negedge fclk);
        chk("post_rst_idle", 32'({rx_valid, busy}), 32'h0);

        // Table of back-to-back frames
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].ack_first) pulse_ack(1'b0);
            send_frame(1'b0, vecs[i].b, vecs[i].stop, 1'b0, 1'b0);
            chk($sformatf("vec%0d_data", i), 32'(rx_data), 32'(vecs[i].e_data));
            chk($sformatf("vec%0d_valid", i), 32'(rx_valid), 32'(vecs[i].e_valid));
            chk($sformatf("vec%0d_fe", i), 32'(frame_err), 32'(vecs[i].e_fe));
            chk($sformatf("vec%0d_ov", i), 32'(overrun_err), 32'(vecs[i].e_ov));
            chk($sformatf("vec%0d_pe", i), 32'(parity_err), 32'h0);
        end

        // Acknowledge clears valid and flags on the next cycle
        pulse_ack(1'b0);
        chk("ack_clear", 32'({rx_valid, frame_err, overrun_err}), 32'h0);

        // Start-bit glitch of two ticks
        align();
        rxd = 1'b0;
        repeat (12) @(negedge fclk);
        chk("glitch_busy_hi", 32'(busy), 32'h1);
        repeat (4) @(negedge fclk);
        rxd = 1'b1;
        repeat (48) @(negedge fclk);
        chk("glitch_busy_lo", 32'(busy), 32'h0);
        chk("glitch_no_frame", 32'({rx_valid, frame_err, overrun_err}), 32'h0);

        // Break: stop bit low, line low for 20 bit times
        send_bits(1'b0, 8'h3C, 1'b0, 1'b0);
        rxd = 1'b0;
        repeat (20) bit_time();
        chk("brk_data", 32'(rx_data), 32'h3C);
        chk("brk_valid_fe", 32'({rx_valid, frame_err}), 32'h3);
        chk("brk_busy", 32'(busy), 32'h1);
        rxd = 1'b1;
        repeat (32) @(negedge fclk);
        chk("brk_idle", 32'(busy), 32'h0);
        chk("brk_no_second", 32'({rx_valid, overrun_err}), 32'h2);

        // Latency and acknowledge coincident with completion
        pulse_ack(1'b0);
        lat = 0;
        fork
            send_frame(1'b0, 8'h11, 1'b1, 1'b0, 1'b0);
            begin
                align();
                while (lat < 2000 && !rx_valid) begin
                    @(negedge fclk);
                    lat++;
                end
            end
        join
        chk("latency_window", 32'(lat >= 590 && lat <= 630), 32'h1);
        chk("lat_data", 32'(rx_data), 32'h11);
        send_frame(1'b0, 8'h33, 1'b1, 1'b0, 1'b0);
        chk("ovr_set", 32'({rx_data, overrun_err}), 32'({8'h11, 1'b1}));
        fork
            send_frame(1'b0, 8'h22, 1'b1, 1'b0, 1'b0);
            begin
                align();
                repeat (lat - 2) @(negedge fclk);
                rd_ack = 1'b1;
                @(negedge fclk);
                rd_ack = 1'b0;
            end
        join
        chk("coinc_data", 32'(rx_data), 32'h22);
        chk("coinc_valid_ov", 32'({rx_valid, overrun_err}), 32'h2);

        // Even parity
        send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
        chk("par_ok_data", 32'(rx_data_p), 32'h07);
        chk("par_ok", 32'({rx_valid_p, parity_err_p, frame_err_p}), 32'h4);
        pulse_ack(1'b1);
        send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b0);
        chk("par_bad", 32'({rx_valid_p, parity_err_p}), 32'h3);
        for (int i = 0; i < 6; i++) begin
            pulse_ack(1'b1);
            rb    = 8'($urandom);
            rpbit = 1'($urandom_range(0, 1));
            send_frame(1'b1, rb, 1'b1, 1'b1, rpbit);
            chk($sformatf("rpar%0d_data", i), 32'(rx_data_p), 32'(rb));
            chk($sformatf("rpar%0d_pe", i), 32'(parity_err_p),
                32'((($countones(rb) + int'(rpbit)) % 2) != 0));
        end

        // Reset during data bit 4 of 0xFF
        align();
        rxd = 1'b0;
        bit_time();
        for (int i = 0; i < 4; i++) begin
            rxd = 1'b1;
            bit_time();
        end
        repeat (32) @(negedge fclk);
        rst = 1'b1;
        #1;
        chk("midrst_data", 32'(rx_data), 32'h0);
        chk("midrst_flags", 32'({rx_valid, frame_err, parity_err, overrun_err, busy}), 32'h0);
        @(negedge fclk);
        repeat (4) @(negedge fclk);
        rst = 1'b0;
        repeat (16) @(negedge fclk);
        send_frame(1'b0, 8'h5A, 1'b1, 1'b0, 1'b0);
        chk("after_rst_data", 32'(rx_data), 32'h5A);
        chk("after_rst_flags", 32'({rx_valid, frame_err, overrun_err}), 32'h4);

        // Random frames against a frame-level model
        m_data = 8'h5A; m_valid = 1'b1; m_fe = 1'b0; m_ov = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rb    = 8'($urandom);
            rstop = ($urandom_range(0, 3) != 0);
            rack  = 1'($urandom_range(0, 1));
            if (rack) begin
                pulse_ack(1'b0);
                if (m_valid) begin
                    m_valid = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
                end
            end
            send_frame(1'b0, rb, rstop, 1'b0, 1'b0);
            if (!m_valid) begin
                m_data = rb; m_valid = 1'b1; m_fe = !rstop; m_ov = 1'b0;
            end else begin
                m_ov = 1'b1;
            end
            chk($sformatf("rnd%0d_data", i), 32'(rx_data), 32'(m_data));
            chk($sformatf("rnd%0d_valid", i), 32'(rx_valid), 32'(m_valid));
            chk($sformatf("rnd%0d_fe", i), 32'(frame_err), 32'(m_fe));
            chk($sformatf("rnd%0d_ov", i), 32'(overrun_err), 32'(m_ov));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
